// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding and default timing for the blink sequencer.
package blink_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  localparam logic [31:0] DEF_TICK_DIV = 32'd1000;
  localparam logic [7:0] DEF_ON_TICKS = 8'd4;
  localparam logic [7:0] DEF_OFF_TICKS = 8'd4;
  localparam logic [7:0] DEF_GAP_TICKS = 8'd16;
  localparam int CNT_W = 4;
endpackage

// File: rtl/blink_tick.sv
// blink_tick: prescaler pulsing tick every TICK_DIV cycles, with sync clear.
module blink_tick #(
  parameter logic [31:0] TICK_DIV = blink_pkg::DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [31:0] cnt;
  assign tick = (cnt == TICK_DIV - 32'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 32'd1;
endmodule

// File: rtl/blink_seq_arb.sv
// blink_seq_arb: round-robin, non-preemptive sharing of one LED pair among NREQ requesters.
module blink_seq_arb
  import blink_pkg::*;
#(
  parameter int NREQ = 4,
  parameter logic [31:0] TICK_DIV = DEF_TICK_DIV,
  parameter logic [7:0] ON_TICKS = DEF_ON_TICKS,
  parameter logic [7:0] OFF_TICKS = DEF_OFF_TICKS,
  parameter logic [7:0] GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic [NREQ-1:0] req,
  input  logic [CNT_W*NREQ-1:0] cnt_i,
  output logic [NREQ-1:0] grant,
  output logic busy,
  output logic [NREQ-1:0] done,
  output logic out1,
  output logic out2
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t state, state_n;
  logic [7:0] phase, phase_n, lim;
  logic [CNT_W-1:0] rem, rem_n, slice;
  logic [PW-1:0] ptr, ptr_n, pick;
  logic [NREQ-1:0] grant_n, done_n;
  logic out1_n, tick, end_ph;

  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    rr_pick = p;
    for (int k = NREQ - 1; k >= 0; k--)
      if (r[(int'(p) + k) % NREQ]) rr_pick = PW'((int'(p) + k) % NREQ);
  endfunction

  blink_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .tick(tick)
  );

  assign busy = (state != IDLE);
  assign out2 = ~out1;
  assign pick = rr_pick(req, ptr);
  assign slice = cnt_i[CNT_W*pick +: CNT_W];
  assign lim = (state == ON) ? ON_TICKS - 8'd1 : (state == OFF) ? OFF_TICKS - 8'd1 : GAP_TICKS - 8'd1;
  assign end_ph = tick && (phase == lim);

  always_comb begin
    state_n = state;
    rem_n = rem;
    ptr_n = ptr;
    grant_n = grant;
    done_n = '0;
    out1_n = out1;
    phase_n = (state == IDLE || end_ph) ? 8'd0 : tick ? phase + 8'd1 : phase;
    // the done cycle blocks arbitration so a finished owner cannot re-grab instantly
    if (state == IDLE) begin
      if (|req && !(|done)) begin
        state_n = ON;
        grant_n = NREQ'(1) << pick;
        out1_n = 1'b1;
        rem_n = (slice == '0) ? CNT_W'(1) : slice;
        ptr_n = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
      end
    end else if (end_ph) begin
      if (state == ON) begin
        state_n = OFF;
        out1_n = 1'b0;
        rem_n = rem - 1'b1;
      end else if (state == OFF && rem != '0) begin
        state_n = ON;
        out1_n = 1'b1;
      end else if (state == OFF && GAP_TICKS != 8'd0) begin
        state_n = GAP;
      end else begin
        state_n = IDLE;
        grant_n = '0;
        done_n = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      rem <= '0;
      ptr <= '0;
      grant <= '0;
      done <= '0;
      out1 <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      rem <= rem_n;
      ptr <= ptr_n;
      grant <= grant_n;
      done <= done_n;
      out1 <= out1_n;
    end
endmodule

// File: tb/tb_blink_seq_arb.sv
// tb_blink_seq_arb: scoreboard bench comparing per-cycle LED/grant traces against the burst timing.
module tb_blink_seq_arb;
  localparam int N = 4;
  localparam int W = 2 * N + 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [4*N-1:0] cnt_i = '0;
  logic [N-1:0] grant, done;
  logic busy, out1, out2;
  logic [W-1:0] sb[$];
  logic [W-1:0] e, got;
  int n_chk = 0;
  int n_fail = 0;

  assign got = {grant, out1, out2, busy, done};

  blink_seq_arb #(
    .NREQ(N),
    .TICK_DIV(32'd2),
    .ON_TICKS(8'd2),
    .OFF_TICKS(8'd1),
    .GAP_TICKS(8'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .cnt_i(cnt_i),
    .grant(grant),
    .busy(busy),
    .done(done),
    .out1(out1),
    .out2(out2)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(logic [N-1:0] g, logic o, logic b, logic [N-1:0] d);
    return {g, o, ~o, b, d};
  endfunction

  // one burst: 4 cycles on / 2 off per blink, 6 cycles gap, then a done cycle
  function automatic void push_burst(int o, int n);
    logic [N-1:0] g;
    g = N'(1) << o;
    for (int b = 0; b < ((n == 0) ? 1 : n); b++) begin
      repeat (4) sb.push_back(ent(g, 1'b1, 1'b1, '0));
      repeat (2) sb.push_back(ent(g, 1'b0, 1'b1, '0));
    end
    repeat (6) sb.push_back(ent(g, 1'b0, 1'b1, '0));
    sb.push_back(ent('0, 1'b0, 1'b0, g));
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #1 n_chk++;
    if (got !== ent('0, 1'b0, 1'b0, '0)) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", got, ent('0, 1'b0, 1'b0, '0));
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) sb.push_back(ent('0, 1'b0, 1'b0, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %b want %b", k, got, e); end
    end
  endtask

  task automatic test_fairness();
    req = 4'b1111;
    cnt_i = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      push_burst(i % 4, 1);
      sb.push_back(ent('0, 1'b0, 1'b0, '0));
    end
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL fairness cyc %0d: got %b want %b", k, got, e); end
      if (k == 56) req = '0;
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    cnt_i = 16'h0002;
    push_burst(0, 2);
    sb.push_back(ent('0, 1'b0, 1'b0, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL single cyc %0d: got %b want %b", k, got, e); end
      if (k == 0) req = '0;
    end
  endtask

  task automatic test_zero_count();
    req = 4'b0100;
    cnt_i = 16'hF0FF;
    push_burst(2, 0);
    sb.push_back(ent('0, 1'b0, 1'b0, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL zero_count cyc %0d: got %b want %b", k, got, e); end
      if (k == 0) req = '0;
    end
  endtask

  task automatic test_non_preempt();
    req = 4'b0001;
    cnt_i = 16'h0001;
    push_burst(0, 1);
    sb.push_back(ent('0, 1'b0, 1'b0, '0));
    push_burst(1, 1);
    sb.push_back(ent('0, 1'b0, 1'b0, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL non_preempt cyc %0d: got %b want %b", k, got, e); end
      if (k == 0) begin req = 4'b0010; cnt_i = 16'h001F; end
      if (k == 14) req = '0;
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0010;
    cnt_i = 16'h0010;
    repeat (2) sb.push_back(ent(4'b0010, 1'b1, 1'b1, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL mid_pre cyc %0d: got %b want %b", k, got, e); end
      if (k == 0) req = '0;
    end
    #2 rst = 1'b1;
    #1 n_chk++;
    if (got !== ent('0, 1'b0, 1'b0, '0)) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want %b", got, ent('0, 1'b0, 1'b0, '0));
    end
    @(negedge clk) rst = 1'b0;
    req = 4'b0110;
    cnt_i = 16'h0110;
    push_burst(1, 1);
    sb.push_back(ent('0, 1'b0, 1'b0, '0));
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk) e = sb.pop_front();
      n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL mid_ptr cyc %0d: got %b want %b", k, got, e); end
      if (k == 0) req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_zero_count();
    test_non_preempt();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
